// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a first-word-fall-through byte FIFO, one pop per frame.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int DATA_BITS     = 8,
  parameter int CLKS_PER_BAUD = 868,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [DATA_BITS-1:0] i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BAUD);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BAUD - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  baud_done;
  logic                  load;

`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  assign baud_done = (baud_cnt_q == BAUD_LAST);
  // A new frame may start from idle or seamlessly on the last stop-bit cycle.
  assign load = i_enable && !i_fifo_empty && !i_rst &&
                ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_done));

  assign o_fifo_rd = load;
  assign o_tx      = tx_q;
  assign o_busy    = busy_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != ST_IDLE) begin
      baud_cnt_d = baud_done ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      ST_START: begin
        if (baud_done) begin
          state_d   = ST_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase

    // Load wins over the STOP->IDLE transition so back-to-back frames have no gap.
    if (load) begin
      state_d    = ST_START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shreg_d    = i_fifo_data;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d   = (^i_fifo_data) ^ PARITY_ODD[0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed scoreboard bench for fifo_uart_tx: FIFO model feeds bytes, a cycle-exact receiver checks the line.
module tb_fifo_uart_tx;

  localparam int DATA_BITS     = 8;
  localparam int CLKS_PER_BAUD = 4;
  localparam int PARITY_ODD    = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLKS_PER_BAUD;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_enable;
  logic [DATA_BITS-1:0] i_fifo_data;
  logic                 i_fifo_empty;
  logic                 o_fifo_rd;
  logic                 o_tx;
  logic                 o_busy;

  logic [DATA_BITS-1:0] mem [16];
  logic [4:0]           wr_ptr = '0;
  logic [4:0]           rd_ptr = '0;
  logic                 force_ff = 1'b0;
  int                   pop_count = 0;
  int                   bad_pop = 0;

  logic [DATA_BITS-1:0] exp_q [$];
  int                   total = 0;
  int                   bad = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BAUD(CLKS_PER_BAUD),
    .PARITY_ODD   (PARITY_ODD)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_enable    (i_enable),
    .i_fifo_data (i_fifo_data),
    .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd   (o_fifo_rd),
    .o_tx        (o_tx),
    .o_busy      (o_busy)
  );

  assign i_fifo_empty = (wr_ptr == rd_ptr);
  assign i_fifo_data  = force_ff ? 8'hFF : mem[rd_ptr[3:0]];

  // FIFO read side: pops on the same edge the strobe is seen.
  always @(posedge clk) begin
    if (o_fifo_rd) begin
      rd_ptr    <= rd_ptr + 1'b1;
      pop_count <= pop_count + 1;
      if (wr_ptr == rd_ptr) bad_pop <= bad_pop + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_BITS-1:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic checkIdle(input int exp_pops);
    checkOutput("idle_tx", {31'd0, o_tx}, 32'd1);
    checkOutput("idle_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("pop_count", pop_count, exp_pops);
  endtask

  // Called at the negedge right after the load edge; returns on the negedge after the frame.
  task automatic recvFrame(input int drop_en_at, input int rst_at);
    logic [DATA_BITS-1:0] b;
    logic [FRAME_BITS-1:0] frame;
    logic exp_rd;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", exp_q.size(), 1);
      return;
    end
    b = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
    frame = {1'b1, (^b) ^ PARITY_ODD[0], b, 1'b0};
`else
    frame = {1'b1, b, 1'b0};
`endif
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c == drop_en_at) i_enable = 1'b0;
      if (c == rst_at) begin
        i_rst = 1'b1;
        #1;
        checkOutput("rst_no_pop", {31'd0, o_fifo_rd}, 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        checkOutput("rst_tx", {31'd0, o_tx}, 32'd1);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        return;
      end
      #1;
      exp_rd = (c == FRAME_CYC - 1) && i_enable && (wr_ptr != rd_ptr);
      checkOutput($sformatf("tx_%02h_c%0d", b, c), {31'd0, o_tx}, {31'd0, frame[c / CLKS_PER_BAUD]});
      checkOutput($sformatf("busy_%02h_c%0d", b, c), {31'd0, o_busy}, 32'd1);
      checkOutput($sformatf("rd_%02h_c%0d", b, c), {31'd0, o_fifo_rd}, {31'd0, exp_rd});
      @(negedge clk);
    end
  endtask

  task automatic startOne(input logic [DATA_BITS-1:0] b);
    @(negedge clk);
    applyStimulus(b);
    #1;
    checkOutput("pop_pulse", {31'd0, o_fifo_rd}, 32'd1);
    checkOutput("pre_start_tx", {31'd0, o_tx}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    i_rst    = 1'b1;
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_tx", {31'd0, o_tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("reset_rd", {31'd0, o_fifo_rd}, 32'd0);
    i_rst = 1'b0;

    // Single byte 0xA5.
    @(negedge clk);
    i_enable = 1'b1;
    #1;
    checkOutput("empty_no_pop", {31'd0, o_fifo_rd}, 32'd0);
    startOne(8'hA5);
    recvFrame(-1, -1);
    #1;
    checkIdle(1);

    // Back-to-back 0x00, 0xFF with no gap.
    @(negedge clk);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    #1;
    checkOutput("b2b_pop", {31'd0, o_fifo_rd}, 32'd1);
    @(negedge clk);
    recvFrame(-1, -1);
    checkOutput("b2b_second_pop", pop_count, 3);
    recvFrame(-1, -1);
    #1;
    checkIdle(3);

    // Empty FIFO for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      checkOutput("empty_rd", {31'd0, o_fifo_rd}, 32'd0);
      checkOutput("empty_tx", {31'd0, o_tx}, 32'd1);
    end

    // Enable dropped during bit 3 of 0x3C; 0x55 waits in the FIFO.
    @(negedge clk);
    applyStimulus(8'h3C);
    applyStimulus(8'h55);
    #1;
    checkOutput("en_pop", {31'd0, o_fifo_rd}, 32'd1);
    @(negedge clk);
    recvFrame(17, -1);
    #1;
    checkIdle(4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      checkOutput("disabled_rd", {31'd0, o_fifo_rd}, 32'd0);
      checkOutput("disabled_busy", {31'd0, o_busy}, 32'd0);
    end
    @(negedge clk);
    i_enable = 1'b1;
    #1;
    checkOutput("reenable_pop", {31'd0, o_fifo_rd}, 32'd1);
    @(negedge clk);
    recvFrame(-1, -1);
    #1;
    checkIdle(5);

    // Reset during bit 5 of 0x81; 0x42 must follow intact.
    @(negedge clk);
    applyStimulus(8'h81);
    applyStimulus(8'h42);
    #1;
    checkOutput("rst_first_pop", {31'd0, o_fifo_rd}, 32'd1);
    @(negedge clk);
    recvFrame(-1, 25);
    checkOutput("post_rst_pop", {31'd0, o_fifo_rd}, 32'd1);
    @(negedge clk);
    recvFrame(-1, -1);
    #1;
    checkIdle(7);

    // Data bus changes after the pop of 0x12.
    @(negedge clk);
    applyStimulus(8'h12);
    #1;
    checkOutput("hold_pop", {31'd0, o_fifo_rd}, 32'd1);
    @(negedge clk);
    force_ff = 1'b1;
    recvFrame(-1, -1);
    force_ff = 1'b0;
    #1;
    checkIdle(8);

    // 0x07 (odd population; parity bit 1 in parity builds).
    startOne(8'h07);
    recvFrame(-1, -1);
    #1;
    checkIdle(9);

    checkOutput("pop_while_empty", bad_pop, 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drains bytes from a first-word-fall-through byte FIFO and serializes each one onto a UART line: 8N1, LSB first, fixed baud divisor.
- Read-side consumer of the byte FIFO. Sits between the FIFO's o_data/o_empty outputs and the pin-level TX line, and drives the FIFO's read strobe.
- Pops exactly one FIFO entry per transmitted frame.

Parameters:
- DATA_BITS, 8: data bits per frame (5..8 legal).
- CLKS_PER_BAUD, 868: clk cycles per bit period (100 MHz / 115200). Minimum 2. Baud counter width is $clog2(CLKS_PER_BAUD).
- PARITY_ODD, 0: parity sense; only used when UART_TX_PARITY_EN is defined (0 = even, 1 = odd).

Ports:
- clk  in  1  system clock; all logic on posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_enable  in  1  permits a new frame to start; does not abort a frame in progress.
- i_fifo_data  in  DATA_BITS  FIFO head word; valid whenever i_fifo_empty=0.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_rd  out  1  pop strobe; FIFO advances on the same clk edge.
- o_tx  out  1  serial line, idle high, registered.
- o_busy  out  1  high while a frame is on the line (START through the last STOP cycle).

Behaviour:
- Interface decided: one clock, clk; reset i_rst is synchronous and active-high.
- Reset values: state IDLE, o_tx=1, o_busy=0, o_fifo_rd=0, baud counter=0, bit counter=0, shift register=0.
- States: IDLE, START, DATA, (PARITY), STOP.
- Load condition: load = i_enable && !i_fifo_empty && !i_rst && (state==IDLE || last cycle of STOP).
- o_fifo_rd is combinational and equals load. It is therefore a single-cycle pulse, at most one per frame, and never asserted while empty.
- On a load edge:
  - shift register <= i_fifo_data
  - state <= START
  - o_tx <= 0
  - baud counter <= 0
- Latency: o_tx falls on the first edge after the cycle in which o_fifo_rd=1.
- Each bit holds for exactly CLKS_PER_BAUD cycles. The baud counter counts 0..CLKS_PER_BAUD-1, and the bit boundary is at count CLKS_PER_BAUD-1.
- START → DATA: o_tx <= shreg[0]. Shift right once per bit boundary.
- DATA → STOP after DATA_BITS bits: o_tx <= 1.
- STOP lasts one bit period. At its last cycle:
  - If load holds: go straight to START. No idle gap, so the frame period is exactly (DATA_BITS+2)*CLKS_PER_BAUD.
  - Otherwise go to IDLE with o_tx=1.
- i_enable deasserted mid-frame: the current frame finishes normally, then the block stays in IDLE.
- i_fifo_empty rising mid-frame has no effect on the current frame.
- Reset mid-frame:
  - o_tx=1 on the next edge; the partially sent byte is lost.
  - No pop occurs in the reset cycle.
  - The FIFO entry already popped is not re-sent.
- Data that changes on i_fifo_data after the pop has no effect, because the byte is latched at the pop.
- o_busy <= 1 on a load edge; o_busy <= 0 on the edge leaving STOP to IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting one bit period.
  - Parity bit = ^data XOR PARITY_ODD, computed from the latched byte at load time.
  - Frame is DATA_BITS+3 bit periods; back-to-back period scales to match.
- Undefined:
  - No PARITY state, no parity logic; PARITY_ODD is ignored.
  - Frame is DATA_BITS+2 bit periods.

Test Plan:
- Single byte, CLKS_PER_BAUD=4: FIFO holds 0xA5, i_enable=1 → o_fifo_rd pulses 1 cycle; o_tx sequence (4 cycles each) is 0, 1,0,1,0,0,1,0,1, 1; o_busy high for 40 cycles; return to IDLE.
- Back-to-back: FIFO holds 0x00, 0xFF → exactly 2 pops, spaced 40 cycles apart; second start bit immediately follows first stop bit; total line activity 80 cycles.
- Empty/enable gating:
  - i_fifo_empty=1 for 100 cycles → o_fifo_rd=0 and o_tx=1 throughout.
  - i_enable dropped during bit 3 of 0x3C → frame completes, no further pop while the FIFO is non-empty.
- Reset mid-frame: i_rst for 1 cycle during bit 5 of 0x81 → o_tx=1 the next cycle; the next byte 0x42 is transmitted intact; pop count equals 2.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): 0x07 → parity bit 1, frame 44 cycles at CLKS_PER_BAUD=4. With PARITY_ODD=1 → parity bit 0.
- Data hold: i_fifo_data driven to 0xFF one cycle after the pop of 0x12 → line still carries 0x12.
